// File: rtl/sys_clk_gen_diff.sv
// Differential reference-clock and downstream reset generator driven from a fast sys_clk.
// Optional rising-edge counter on edge_cnt is built only when CLKGEN_EDGE_CNT_EN is defined.
module sys_clk_gen_diff #(
   parameter int unsigned HALF0      = 5,
   parameter int unsigned HALF1      = 4,
   parameter int unsigned HALF2      = 2,
   parameter int unsigned OFFSET     = 0,
   parameter int unsigned RST_CYCLES = 500,
   parameter int unsigned CNT_W      = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [1:0]  freq_sel,
   output logic        sys_clk_p,
   output logic        sys_clk_n,
   output logic        clk_valid,
   output logic        sys_rst_n_o,
   output logic [31:0] edge_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OFFSET,
      ST_RUN,
      ST_STOPPED
   } state_t;

   // A zero half-period would never toggle, so it is quietly promoted to one.
   localparam logic [CNT_W-1:0] H0       = (HALF0 < 1) ? CNT_W'(1) : CNT_W'(HALF0);
   localparam logic [CNT_W-1:0] H1       = (HALF1 < 1) ? CNT_W'(1) : CNT_W'(HALF1);
   localparam logic [CNT_W-1:0] H2       = (HALF2 < 1) ? CNT_W'(1) : CNT_W'(HALF2);
   localparam logic [CNT_W-1:0] OFS_LAST = (OFFSET > 0) ? CNT_W'(OFFSET - 1) : '0;
   localparam logic [CNT_W-1:0] RST_TGT  = CNT_W'(RST_CYCLES);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   function automatic logic [CNT_W-1:0] selHalf(input logic [1:0] sel);
      case (sel)
         2'd0:    return H0;
         2'd1:    return H1;
         default: return H2;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] halfCnt_q, halfCnt_d;
   logic [CNT_W-1:0] hActive_q, hActive_d;
   logic [CNT_W-1:0] rstCnt_q, rstCnt_d;
   logic             clkP_q, clkP_d;
   logic             clkN_q, clkN_d;
   logic             clkValid_q, clkValid_d;
   logic             rstN_q, rstN_d;
   logic             stopReq;

   assign stopReq = (freq_sel == 2'd3);

   always_comb begin
      state_d    = state_q;
      halfCnt_d  = halfCnt_q;
      hActive_d  = hActive_q;
      rstCnt_d   = rstCnt_q;
      clkP_d     = clkP_q;
      clkValid_d = clkValid_q;
      rstN_d     = rstN_q;

      case (state_q)
         ST_IDLE: begin
            halfCnt_d = '0;
            if (OFFSET > 0) begin
               state_d = ST_OFFSET;
            end else if (stopReq) begin
               state_d    = ST_STOPPED;
               clkP_d     = 1'b0;
               clkValid_d = 1'b0;
               rstN_d     = 1'b0;
               rstCnt_d   = '0;
            end else begin
               state_d   = ST_RUN;
               hActive_d = selHalf(freq_sel);
            end
         end

         ST_OFFSET: begin
            if (halfCnt_q == OFS_LAST) begin
               halfCnt_d = '0;
               if (stopReq) begin
                  state_d    = ST_STOPPED;
                  clkP_d     = 1'b0;
                  clkValid_d = 1'b0;
                  rstN_d     = 1'b0;
                  rstCnt_d   = '0;
               end else begin
                  state_d   = ST_RUN;
                  hActive_d = selHalf(freq_sel);
               end
            end else begin
               halfCnt_d = halfCnt_q + ONE;
            end
         end

         // The end of a low phase is the only point where H or a stop request is sampled.
         ST_RUN: begin
            if (halfCnt_q == hActive_q - ONE) begin
               halfCnt_d = '0;
               if (clkP_q) begin
                  clkP_d = 1'b0;
               end else if (stopReq) begin
                  state_d    = ST_STOPPED;
                  clkValid_d = 1'b0;
                  rstN_d     = 1'b0;
                  rstCnt_d   = '0;
               end else begin
                  clkP_d     = 1'b1;
                  clkValid_d = 1'b1;
                  hActive_d  = selHalf(freq_sel);
                  if (!rstN_q) begin
                     rstCnt_d = rstCnt_q + ONE;
                     if (rstCnt_q + ONE >= RST_TGT) begin
                        rstN_d = 1'b1;
                     end
                  end
               end
            end else begin
               halfCnt_d = halfCnt_q + ONE;
            end
         end

         ST_STOPPED: begin
            clkP_d = 1'b0;
            if (!stopReq) begin
               state_d   = ST_RUN;
               hActive_d = selHalf(freq_sel);
               halfCnt_d = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      clkN_d = ~clkP_d;
   end

   // Every output leaves straight from a flop so the differential pair stays glitch-free.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         halfCnt_q  <= '0;
         hActive_q  <= '0;
         rstCnt_q   <= '0;
         clkP_q     <= 1'b0;
         clkN_q     <= 1'b1;
         clkValid_q <= 1'b0;
         rstN_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         halfCnt_q  <= halfCnt_d;
         hActive_q  <= hActive_d;
         rstCnt_q   <= rstCnt_d;
         clkP_q     <= clkP_d;
         clkN_q     <= clkN_d;
         clkValid_q <= clkValid_d;
         rstN_q     <= rstN_d;
      end
   end

   assign sys_clk_p   = clkP_q;
   assign sys_clk_n   = clkN_q;
   assign clk_valid   = clkValid_q;
   assign sys_rst_n_o = rstN_q;

`ifdef CLKGEN_EDGE_CNT_EN
   logic [31:0] edgeCnt_q;
   logic        riseNow;

   assign riseNow = clkP_d & ~clkP_q;

   // Free-running and wrapping; only the external reset clears it.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         edgeCnt_q <= '0;
      end else if (riseNow) begin
         edgeCnt_q <= edgeCnt_q + 32'd1;
      end
   end

   assign edge_cnt = edgeCnt_q;
`else
   assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_sys_clk_gen_diff.sv
// Directed bench for sys_clk_gen_diff: startup timing, reset sequencing, frequency
// switching, stop/restart, OFFSET startup, asynchronous reset and the edge counter.
module tb_sys_clk_gen_diff;

   logic        sysClk = 1'b0;
   logic        sysRst = 1'b1;
   logic [1:0]  freqSel = 2'd0;
   logic        clkP, clkN, clkValid, rstN;
   logic [31:0] edgeCnt;

   logic        ofsRst = 1'b1;
   logic [1:0]  ofsFreqSel = 2'd0;
   logic        ofsClkP, ofsClkN, ofsClkValid, ofsRstN;
   logic [31:0] ofsEdgeCnt;

   int tests = 0;
   int fails = 0;
   int k = 0;

   always #5 sysClk = ~sysClk;

   sys_clk_gen_diff dut (
      .sys_clk     (sysClk),
      .sys_rst     (sysRst),
      .freq_sel    (freqSel),
      .sys_clk_p   (clkP),
      .sys_clk_n   (clkN),
      .clk_valid   (clkValid),
      .sys_rst_n_o (rstN),
      .edge_cnt    (edgeCnt)
   );

   sys_clk_gen_diff #(.OFFSET(7), .RST_CYCLES(3)) dutOfs (
      .sys_clk     (sysClk),
      .sys_rst     (ofsRst),
      .freq_sel    (ofsFreqSel),
      .sys_clk_p   (ofsClkP),
      .sys_clk_n   (ofsClkN),
      .clk_valid   (ofsClkValid),
      .sys_rst_n_o (ofsRstN),
      .edge_cnt    (ofsEdgeCnt)
   );

   // Advance one sys_clk cycle and sample on the falling edge.
   task automatic step();
      @(posedge sysClk);
      @(negedge sysClk);
      k++;
   endtask

   task automatic test_reset();
      sysRst  = 1'b1;
      freqSel = 2'd0;
      repeat (10) @(negedge sysClk);
      tests++; if (clkP !== 1'b0) begin fails++; $display("[TB] FAIL reset clk_p: got %b expected 0", clkP); end
      tests++; if (clkN !== 1'b1) begin fails++; $display("[TB] FAIL reset clk_n: got %b expected 1", clkN); end
      tests++; if (clkValid !== 1'b0) begin fails++; $display("[TB] FAIL reset clk_valid: got %b expected 0", clkValid); end
      tests++; if (rstN !== 1'b0) begin fails++; $display("[TB] FAIL reset rst_n: got %b expected 0", rstN); end
      tests++; if (edgeCnt !== 32'd0) begin fails++; $display("[TB] FAIL reset edge_cnt: got %0d expected 0", edgeCnt); end
   endtask

   // First rise at cycle 6 after release, then period 10.
   task automatic test_first_edge();
      logic expP;
      sysRst = 1'b0;
      k = 0;
      while (k < 40) begin
         step();
         expP = (k >= 6) && (((k - 6) % 10) < 5);
         tests++; if (clkP !== expP) begin fails++; $display("[TB] FAIL first_edge clk_p cycle %0d: got %b expected %b", k, clkP, expP); end
         tests++; if (clkN !== ~expP) begin fails++; $display("[TB] FAIL first_edge clk_n cycle %0d: got %b expected %b", k, clkN, ~expP); end
         tests++; if (clkValid !== (k >= 6)) begin fails++; $display("[TB] FAIL first_edge clk_valid cycle %0d: got %b", k, clkValid); end
         tests++; if (rstN !== 1'b0) begin fails++; $display("[TB] FAIL first_edge rst_n cycle %0d: got %b expected 0", k, rstN); end
      end
   endtask

   // 500th rising edge lands on cycle 6 + 499*10 = 4996.
   task automatic test_rst_sequence();
      logic expP;
      while (k < 5010) begin
         step();
         expP = ((k - 6) % 10) < 5;
         tests++; if (clkP !== expP) begin fails++; $display("[TB] FAIL rst_seq clk_p cycle %0d: got %b expected %b", k, clkP, expP); end
         tests++; if (clkN !== ~expP) begin fails++; $display("[TB] FAIL rst_seq clk_n cycle %0d: got %b", k, clkN); end
         tests++; if (rstN !== (k >= 4996)) begin fails++; $display("[TB] FAIL rst_seq rst_n cycle %0d: got %b expected %b", k, rstN, (k >= 4996)); end
`ifndef CLKGEN_EDGE_CNT_EN
         tests++; if (edgeCnt !== 32'd0) begin fails++; $display("[TB] FAIL edge_cnt_off cycle %0d: got %0d expected 0", k, edgeCnt); end
`endif
      end
   endtask

   // Switch 0->2 at cycle 5018 (third cycle of a high phase): high ends at 5020,
   // low 5021..5025 still uses H=5, rise at 5026, then period 4.
   task automatic test_freq_switch();
      logic expP;
      while (k < 5018) begin
         step();
         expP = ((k - 6) % 10) < 5;
         tests++; if (clkP !== expP) begin fails++; $display("[TB] FAIL pre_switch clk_p cycle %0d: got %b expected %b", k, clkP, expP); end
      end
      freqSel = 2'd2;
      while (k < 5040) begin
         step();
         if (k <= 5020)      expP = 1'b1;
         else if (k <= 5025) expP = 1'b0;
         else                expP = ((k - 5026) % 4) < 2;
         tests++; if (clkP !== expP) begin fails++; $display("[TB] FAIL freq_switch clk_p cycle %0d: got %b expected %b", k, clkP, expP); end
         tests++; if (clkN !== ~expP) begin fails++; $display("[TB] FAIL freq_switch clk_n cycle %0d: got %b", k, clkN); end
         tests++; if (rstN !== 1'b1) begin fails++; $display("[TB] FAIL freq_switch rst_n cycle %0d: got %b expected 1", k, rstN); end
         tests++; if (clkValid !== 1'b1) begin fails++; $display("[TB] FAIL freq_switch clk_valid cycle %0d: got %b expected 1", k, clkValid); end
      end
   endtask

   // Stop requested on the first low cycle (5040); the low phase ends at 5042 and parks.
   // Restart with freq_sel=1 at 5061: rise at 5065, period 8, 500th new edge at 9057.
   task automatic test_stop_restart();
      logic expP;
      freqSel = 2'd3;
      while (k < 5060) begin
         step();
         tests++; if (clkP !== 1'b0) begin fails++; $display("[TB] FAIL stop clk_p cycle %0d: got %b expected 0", k, clkP); end
         tests++; if (clkN !== 1'b1) begin fails++; $display("[TB] FAIL stop clk_n cycle %0d: got %b expected 1", k, clkN); end
         tests++; if (clkValid !== (k < 5042)) begin fails++; $display("[TB] FAIL stop clk_valid cycle %0d: got %b expected %b", k, clkValid, (k < 5042)); end
         tests++; if (rstN !== (k < 5042)) begin fails++; $display("[TB] FAIL stop rst_n cycle %0d: got %b expected %b", k, rstN, (k < 5042)); end
      end
      freqSel = 2'd1;
      while (k < 9070) begin
         step();
         expP = (k >= 5065) && (((k - 5065) % 8) < 4);
         tests++; if (clkP !== expP) begin fails++; $display("[TB] FAIL restart clk_p cycle %0d: got %b expected %b", k, clkP, expP); end
         tests++; if (clkN !== ~expP) begin fails++; $display("[TB] FAIL restart clk_n cycle %0d: got %b", k, clkN); end
         tests++; if (clkValid !== (k >= 5065)) begin fails++; $display("[TB] FAIL restart clk_valid cycle %0d: got %b", k, clkValid); end
         tests++; if (rstN !== (k >= 9057)) begin fails++; $display("[TB] FAIL restart rst_n cycle %0d: got %b expected %b", k, rstN, (k >= 9057)); end
`ifdef CLKGEN_EDGE_CNT_EN
         if (k == 9009) begin
            tests++; if (edgeCnt !== 32'd1000) begin fails++; $display("[TB] FAIL edge_cnt_1000: got %0d expected 1000", edgeCnt); end
         end
`else
         tests++; if (edgeCnt !== 32'd0) begin fails++; $display("[TB] FAIL edge_cnt_off cycle %0d: got %0d expected 0", k, edgeCnt); end
`endif
      end
   endtask

   // Next rises after 9070 are at 9073 and 9081.
   task automatic test_edge_wrap();
`ifdef CLKGEN_EDGE_CNT_EN
      force dut.edgeCnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.edgeCnt_q;
      while (k < 9073) step();
      tests++; if (edgeCnt !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL edge_wrap_max: got %h expected ffffffff", edgeCnt); end
      while (k < 9081) step();
      tests++; if (edgeCnt !== 32'd0) begin fails++; $display("[TB] FAIL edge_wrap_zero: got %h expected 00000000", edgeCnt); end
`else
      while (k < 9081) step();
      tests++; if (edgeCnt !== 32'd0) begin fails++; $display("[TB] FAIL edge_cnt_off end: got %0d expected 0", edgeCnt); end
`endif
   endtask

   // OFFSET=7: first rise 1+7+5 = 13 cycles after release; async reset at cycle 15 (high).
   task automatic test_offset_async();
      logic expP;
      ofsFreqSel = 2'd0;
      @(negedge sysClk);
      ofsRst = 1'b0;
      for (int j = 1; j <= 15; j++) begin
         @(posedge sysClk);
         @(negedge sysClk);
         expP = (j >= 13);
         tests++; if (ofsClkP !== expP) begin fails++; $display("[TB] FAIL offset clk_p cycle %0d: got %b expected %b", j, ofsClkP, expP); end
         tests++; if (ofsClkN !== ~expP) begin fails++; $display("[TB] FAIL offset clk_n cycle %0d: got %b", j, ofsClkN); end
         tests++; if (ofsClkValid !== expP) begin fails++; $display("[TB] FAIL offset clk_valid cycle %0d: got %b expected %b", j, ofsClkValid, expP); end
         tests++; if (ofsRstN !== 1'b0) begin fails++; $display("[TB] FAIL offset rst_n cycle %0d: got %b expected 0", j, ofsRstN); end
      end
      #2;
      ofsRst = 1'b1;
      #1;
      tests++; if (ofsClkP !== 1'b0) begin fails++; $display("[TB] FAIL async_rst clk_p: got %b expected 0", ofsClkP); end
      tests++; if (ofsClkN !== 1'b1) begin fails++; $display("[TB] FAIL async_rst clk_n: got %b expected 1", ofsClkN); end
      tests++; if (ofsClkValid !== 1'b0) begin fails++; $display("[TB] FAIL async_rst clk_valid: got %b expected 0", ofsClkValid); end
      tests++; if (ofsRstN !== 1'b0) begin fails++; $display("[TB] FAIL async_rst rst_n: got %b expected 0", ofsRstN); end
   endtask

   initial begin
      test_reset();
      test_first_edge();
      test_rst_sequence();
      test_freq_switch();
      test_stop_restart();
      test_edge_wrap();
      test_offset_async();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sys_clk_gen_diff.md
Name: sys_clk_gen_diff

Overview:
- Synthesizable differential reference-clock and reset generator for the PCIe/QDMA-HBM board environment.
- Divides the fast `sys_clk` into a selectable 100/125/250 MHz-class differential pair (`sys_clk_p`/`sys_clk_n`).
- Produces an active-low downstream reset, `sys_rst_n_o`, held low for a fixed number of generated-clock cycles.
- Feeds the endpoint (`top`) clock pins and the root-port model.

Parameters:
- HALF0, 5: half-period, in `sys_clk` cycles, for `freq_sel`=0 (100 MHz class).
- HALF1, 4: half-period for `freq_sel`=1 (125 MHz class).
- HALF2, 2: half-period for `freq_sel`=2 (250 MHz class).
- OFFSET, 0: extra `sys_clk` cycles the output stays low before the first half-period count after reset.
- RST_CYCLES, 500: rising edges of `sys_clk_p` during which `sys_rst_n_o` stays low.
- CNT_W, 16: width of the internal half-period, offset and reset counters; must hold max(HALFx, OFFSET, RST_CYCLES).

Ports:
- sys_clk, input, 1: single clock; all logic is on its rising edge.
- sys_rst, input, 1: asynchronous active-high reset.
- freq_sel, input, 2: 0/1/2 select HALF0/HALF1/HALF2; 3 stops the clock.
- sys_clk_p, output, 1: generated clock, positive leg.
- sys_clk_n, output, 1: always the complement of `sys_clk_p`.
- clk_valid, output, 1: high while the generated clock is running.
- sys_rst_n_o, output, 1: active-low reset for downstream logic.
- edge_cnt, output, 32: count of rising edges of `sys_clk_p` (see Optional Feature).

Behaviour:
- Reset values while `sys_rst`=1: `sys_clk_p`=0, `sys_clk_n`=1, `clk_valid`=0, `sys_rst_n_o`=0, `edge_cnt`=0, all counters 0.
- All outputs are registered.
- Reset assertion is asynchronous and takes effect mid-operation, aborting any phase immediately.
- State machine states:
  - IDLE: one cycle after reset release.
  - OFFSET: `sys_clk_p` held low for OFFSET cycles; skipped when OFFSET=0.
  - RUN: toggling.
  - STOPPED: parked.
- Active half-period H is latched from `freq_sel` only at a low-to-high decision point: the OFFSET-to-RUN entry, or the end of a low phase. A change during a high phase or mid-low-phase is deferred, so there are no runt pulses.
- RUN low phase: lasts H cycles, then `sys_clk_p` rises.
- RUN high phase: lasts the same latched H, then `sys_clk_p` falls.
- Timing from reset release with `freq_sel` steady:
  - First rising edge of `sys_clk_p` occurs after 1 + OFFSET + H `sys_clk` edges.
  - Period is 2H; duty cycle is exactly 50%.
- `clk_valid` rises together with the first `sys_clk_p` rising edge.
- `freq_sel`=3 seen at a low-to-high decision point: enter STOPPED, `sys_clk_p` parks low, `clk_valid`=0, `sys_rst_n_o` forced 0, reset counter cleared. A 3 seen during a high phase completes the high phase first.
- Leaving STOPPED: a `freq_sel` other than 3 restarts the clock via a fresh low phase of H (no OFFSET), and the reset sequence re-runs in full.
- Changing between running frequencies (0/1/2) does not affect `sys_rst_n_o`.
- Reset counter:
  - Increments on each `sys_clk_p` rising edge while `sys_rst_n_o`=0.
  - `sys_rst_n_o` goes high in the same cycle that the RST_CYCLES-th rising edge is produced, then stays high.
  - Saturates; no wrap.
- HALFx values below 1 are illegal; implementations may treat 0 as 1.

Optional Feature:
- Macro: CLKGEN_EDGE_CNT_EN.
- Defined: `edge_cnt` is a 32-bit free-running counter of `sys_clk_p` rising edges.
  - Cleared only by `sys_rst`.
  - Holds while STOPPED.
  - Wraps from 0xFFFF_FFFF to 0.
- Not defined: the port exists, is tied to 0, and no counter logic is synthesized.

Test Plan:
- Reset held 10 cycles, `freq_sel`=0, defaults → `sys_clk_p` first rises 6 cycles after release; period 10 cycles; `sys_clk_n`=~`sys_clk_p` every cycle; `clk_valid` rises with that edge.
- Defaults, `freq_sel`=0 → `sys_rst_n_o` low until the 500th `sys_clk_p` rising edge, high from that cycle onward (5000 `sys_clk` cycles after the first edge minus one period).
- Running at `freq_sel`=0, switch to 2 in mid-high phase → high phase still lasts 5 cycles; the next low phase is 5, then period becomes 4; `sys_rst_n_o` unchanged.
- `freq_sel`=3 while running with reset released → clock parks low after current phase, `clk_valid`=0, `sys_rst_n_o`=0; then `freq_sel`=1 → period 8, `sys_rst_n_o` rises after 500 new edges.
- OFFSET=7, HALF0=5 → first rising edge 13 cycles after reset release; assert `sys_rst` mid-high-phase → `sys_clk_p`=0 and `sys_clk_n`=1 immediately (asynchronous).
- With CLKGEN_EDGE_CNT_EN, 1000 edges → `edge_cnt`=1000; preload near 0xFFFF_FFFF via force → wraps to 0. Without the macro → `edge_cnt` always 0.
